ac_motor_ramp_control: RTL and testbench
========================================

AC_MOTOR_RAMP_CONTROL -- requirements
Module: ac_motor_ramp_control

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 1000, clk cycles per ramp step (2..65535).
REQ-002 SHALL have parameter STEP, default 1, frequency increment per ramp step (1..4095).
REQ-003 SHALL have parameter U_BOOST, default 256, u_str offset at zero frequency (0..4095).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  run request, level-sampled.
REQ-007 SHALL have port stop  input  1  stop request, level-sampled.
REQ-008 SHALL have port target_freq  input  12  requested frequency word, unsigned.
REQ-009 SHALL have port fault  input  1  external fault (overcurrent etc.), level-sampled.
REQ-010 SHALL have port fault_clr  input  1  fault acknowledge.
REQ-011 SHALL have port frequency  output  12  frequency word to the sine/sector generator.
REQ-012 SHALL have port u_str  output  12  voltage amplitude word to the vector-time block.
REQ-013 SHALL have port pwm_en  output  1  switching enable for the vector control stage.
REQ-014 SHALL have port at_speed  output  1  high when state RUN and frequency == target_freq.
REQ-015 SHALL have port state  output  3  IDLE=0, ACCEL=1, RUN=2, DECEL=3, STOPPING=4, FAULT=5.

Function
REQ-016 SHALL use a prescaler counting 0..RAMP_DIV-1, wrapping to 0; tick = cycle where count == RAMP_DIV-1; counter held at 0 in IDLE and FAULT.
REQ-017 SHALL, on a tick in ACCEL, set frequency <= min(frequency+STEP, target_freq), computed 13 bits wide, no wrap.
REQ-018 SHALL, on a tick in DECEL, set frequency <= max(frequency-STEP, target_freq), no underflow.
REQ-019 SHALL, on a tick in STOPPING, set frequency <= max(frequency-STEP, 0).
REQ-020 SHALL hold frequency constant on non-tick cycles and in RUN.
REQ-021 SHALL register u_str <= min(4095, U_BOOST + frequency) every cycle (one cycle behind frequency), 0 in IDLE and FAULT.
REQ-022 SHALL drive pwm_en = 1 exactly in ACCEL, RUN, DECEL, STOPPING (registered with state).
REQ-023 Priority every cycle: fault > stop > start > target tracking.
REQ-024 IDLE: start=1 and stop=0 and target_freq>0 -> ACCEL; else stay.
REQ-025 ACCEL: frequency==target_freq -> RUN; target_freq<frequency -> DECEL; stop -> STOPPING.
REQ-026 DECEL: frequency==target_freq -> RUN; target_freq>frequency -> ACCEL; stop -> STOPPING.
REQ-027 RUN: target_freq>frequency -> ACCEL; target_freq<frequency -> DECEL; stop -> STOPPING.
REQ-028 STOPPING: frequency==0 -> IDLE; start ignored until IDLE reached.
REQ-029 Any state: fault=1 -> FAULT next cycle; frequency, u_str, pwm_en forced 0 same edge.
REQ-030 FAULT: leave to IDLE only when fault_clr=1 and fault=0 in the same cycle; fault_clr with fault=1 ignored.
REQ-031 target_freq change mid-ramp SHALL take effect at the next state evaluation; no latching.
REQ-032 target_freq==0 in RUN/ACCEL SHALL decelerate via DECEL to 0 and remain RUN (pwm_en=1) until stop.

Reset
REQ-033 rst=1 SHALL set state=IDLE, frequency=0, u_str=0, pwm_en=0, at_speed=0, prescaler=0 on the next edge, overriding fault and all commands, including mid-ramp.

Verification (RAMP_DIV=4, STEP=16, U_BOOST=256)
REQ-034 rst, then start=1, target_freq=64 -> ACCEL; frequency 16,32,48,64 at 4-cycle intervals; RUN; at_speed=1; u_str=320.
REQ-035 In RUN at 64, target_freq=40 -> DECEL; frequency 48 then 40 (clamped); RUN.
REQ-036 target_freq=4095, U_BOOST=256 -> ACCEL up to 4095 without wrap; u_str saturates at 4095 once frequency>=3839.
REQ-037 During ACCEL at 32, stop=1 -> STOPPING; 16, 0; IDLE; pwm_en=0.
REQ-038 In RUN, fault=1 -> next cycle FAULT, frequency=0, pwm_en=0; fault_clr with fault=1 stays FAULT; fault=0 + fault_clr -> IDLE.
REQ-039 rst asserted mid-ACCEL for one cycle -> all outputs 0, IDLE; ramp restarts from 0 on next start.

Source files
------------

// File: rtl/ac_motor_ramp_control.sv
// Ramp controller for a V/f AC motor drive: ramps the frequency word toward
// a target at a fixed rate and derives a boosted, saturated voltage amplitude.
module ac_motor_ramp_control #(
    parameter int RAMP_DIV = 1000,
    parameter int STEP     = 1,
    parameter int U_BOOST  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [11:0] target_freq,
    input  logic        fault,
    input  logic        fault_clr,
    output logic [11:0] frequency,
    output logic [11:0] u_str,
    output logic        pwm_en,
    output logic        at_speed,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCEL    = 3'd1,
        RUN      = 3'd2,
        DECEL    = 3'd3,
        STOPPING = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(RAMP_DIV - 1);
    localparam logic [12:0] STEP13    = 13'(STEP);
    localparam logic [11:0] STEP12    = 12'(STEP);
    localparam logic [12:0] BOOST13   = 13'(U_BOOST);
    localparam logic [12:0] U_MAX13   = 13'd4095;

    state_t      cur_state;
    state_t      next_state;
    logic [15:0] presc;
    logic        tick;
    logic [11:0] next_freq;
    logic [12:0] freq13;
    logic [12:0] tgt13;
    logic [12:0] freq_up;
    logic [12:0] u_sum;
    logic [11:0] u_next;
    logic        hold_now;
    logic        hold_next;

    assign freq13    = {1'b0, frequency};
    assign tgt13     = {1'b0, target_freq};
    assign freq_up   = freq13 + STEP13;
    assign u_sum     = freq13 + BOOST13;
    assign u_next    = (u_sum > U_MAX13) ? 12'd4095 : u_sum[11:0];
    assign tick      = (presc == PRESC_MAX);
    assign hold_now  = (cur_state == IDLE) || (cur_state == FAULT);
    assign hold_next = (next_state == IDLE) || (next_state == FAULT);

    assign state    = cur_state;
    assign at_speed = (cur_state == RUN) && (frequency == target_freq);

    // Frequency moves only on prescaler ticks; sums are 13 bits so nothing wraps.
    always_comb begin
        next_freq = frequency;
        if (tick) begin
            case (cur_state)
                ACCEL:    next_freq = (freq_up > tgt13) ? target_freq : freq_up[11:0];
                DECEL:    next_freq = (freq13 >= tgt13 + STEP13) ? (frequency - STEP12) : target_freq;
                STOPPING: next_freq = (freq13 >= STEP13) ? (frequency - STEP12) : 12'd0;
                default:  next_freq = frequency;
            endcase
        end
    end

    // Fault outranks stop, stop outranks start, start outranks target tracking.
    always_comb begin
        next_state = cur_state;
        if (fault) begin
            next_state = FAULT;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start && !stop && (target_freq != 12'd0))
                        next_state = ACCEL;
                end
                ACCEL: begin
                    if (stop)                          next_state = STOPPING;
                    else if (frequency == target_freq) next_state = RUN;
                    else if (target_freq < frequency)  next_state = DECEL;
                end
                DECEL: begin
                    if (stop)                          next_state = STOPPING;
                    else if (frequency == target_freq) next_state = RUN;
                    else if (target_freq > frequency)  next_state = ACCEL;
                end
                RUN: begin
                    if (stop)                          next_state = STOPPING;
                    else if (target_freq > frequency)  next_state = ACCEL;
                    else if (target_freq < frequency)  next_state = DECEL;
                end
                STOPPING: begin
                    if (frequency == 12'd0) next_state = IDLE;
                end
                FAULT: begin
                    if (fault_clr) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered against the next state so a fault zeroes them on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            frequency <= 12'd0;
            u_str     <= 12'd0;
            pwm_en    <= 1'b0;
            presc     <= 16'd0;
        end else begin
            cur_state <= next_state;
            frequency <= (next_state == FAULT) ? 12'd0 : next_freq;
            u_str     <= hold_next ? 12'd0 : u_next;
            pwm_en    <= !hold_next;
            if (hold_now || hold_next)
                presc <= 16'd0;
            else if (tick)
                presc <= 16'd0;
            else
                presc <= presc + 16'd1;
        end
    end

endmodule

// File: tb/tb_ac_motor_ramp_control.sv
// Directed self-checking bench for ac_motor_ramp_control with RAMP_DIV=4,
// STEP=16, U_BOOST=256; expected values are worked out by hand.
module tb_ac_motor_ramp_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [11:0] target_freq;
    logic        fault;
    logic        fault_clr;
    logic [11:0] frequency;
    logic [11:0] u_str;
    logic        pwm_en;
    logic        at_speed;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    ac_motor_ramp_control #(.RAMP_DIV(4), .STEP(16), .U_BOOST(256)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .target_freq(target_freq), .fault(fault), .fault_clr(fault_clr),
        .frequency(frequency), .u_str(u_str), .pwm_en(pwm_en),
        .at_speed(at_speed), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exhausted, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_freq(input logic [11:0] f, input int budget, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (frequency === f) ok = 1'b1;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        int cycles;
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (state === s) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; target_freq = 12'd0; fault = 1'b0; fault_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (frequency !== 12'd0) begin n_err++; $display("[TB] FAIL reset_freq: got %0d expected 0", frequency); end
        n_cmp++; if (u_str !== 12'd0) begin n_err++; $display("[TB] FAIL reset_ustr: got %0d expected 0", u_str); end
        n_cmp++; if (pwm_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_pwm: got %0b expected 0", pwm_en); end
        n_cmp++; if (at_speed !== 1'b0) begin n_err++; $display("[TB] FAIL reset_atspeed: got %0b expected 0", at_speed); end
        // start with a zero target must not leave IDLE
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL idle_zero_target: got %0d expected 0", state); end
    endtask

    task automatic test_accel();
        target_freq = 12'd64; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("[TB] FAIL accel_enter_state: got %0d expected 1", state); end
        n_cmp++; if (pwm_en !== 1'b1) begin n_err++; $display("[TB] FAIL accel_enter_pwm: got %0b expected 1", pwm_en); end
        n_cmp++; if (u_str !== 12'd256) begin n_err++; $display("[TB] FAIL accel_enter_ustr: got %0d expected 256", u_str); end
        repeat (3) tick();
        n_cmp++; if (frequency !== 12'd0) begin n_err++; $display("[TB] FAIL accel_pre_tick: got %0d expected 0", frequency); end
        tick();
        n_cmp++; if (frequency !== 12'd16) begin n_err++; $display("[TB] FAIL accel_step1: got %0d expected 16", frequency); end
        for (int k = 2; k <= 4; k++) begin
            repeat (4) tick();
            n_cmp++; if (frequency !== 12'(16 * k)) begin n_err++; $display("[TB] FAIL accel_step%0d: got %0d expected %0d", k, frequency, 16 * k); end
        end
        n_cmp++; if (u_str !== 12'd304) begin n_err++; $display("[TB] FAIL accel_ustr_lag: got %0d expected 304", u_str); end
        tick();
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL run_state: got %0d expected 2", state); end
        n_cmp++; if (at_speed !== 1'b1) begin n_err++; $display("[TB] FAIL run_atspeed: got %0b expected 1", at_speed); end
        n_cmp++; if (u_str !== 12'd320) begin n_err++; $display("[TB] FAIL run_ustr: got %0d expected 320", u_str); end
    endtask

    task automatic test_decel();
        bit ok;
        int cyc;
        target_freq = 12'd40;
        tick();
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("[TB] FAIL decel_state: got %0d expected 3", state); end
        wait_freq(12'd48, 8, ok, cyc);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL decel_48: got %0d expected 48", frequency); end
        wait_freq(12'd40, 8, ok, cyc);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL decel_clamp40: got %0d expected 40", frequency); end
        n_cmp++; if (cyc != 4) begin n_err++; $display("[TB] FAIL decel_interval: got %0d expected 4", cyc); end
        tick();
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL decel_run: got %0d expected 2", state); end
        n_cmp++; if (u_str !== 12'd296) begin n_err++; $display("[TB] FAIL decel_ustr: got %0d expected 296", u_str); end
        n_cmp++; if (at_speed !== 1'b1) begin n_err++; $display("[TB] FAIL decel_atspeed: got %0b expected 1", at_speed); end
    endtask

    task automatic test_target_zero();
        bit ok;
        target_freq = 12'd0;
        tick();
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("[TB] FAIL zero_decel: got %0d expected 3", state); end
        wait_state(3'd2, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL zero_run: got %0d expected 2", state); end
        n_cmp++; if (frequency !== 12'd0) begin n_err++; $display("[TB] FAIL zero_freq: got %0d expected 0", frequency); end
        n_cmp++; if (pwm_en !== 1'b1) begin n_err++; $display("[TB] FAIL zero_pwm: got %0b expected 1", pwm_en); end
        stop = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd4) begin n_err++; $display("[TB] FAIL zero_stopping: got %0d expected 4", state); end
        tick();
        stop = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL zero_idle: got %0d expected 0", state); end
        n_cmp++; if (pwm_en !== 1'b0) begin n_err++; $display("[TB] FAIL zero_idle_pwm: got %0b expected 0", pwm_en); end
    endtask

    task automatic test_stop();
        bit ok;
        int cyc;
        pulse_reset();
        target_freq = 12'd64; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        n_cmp++; if (frequency !== 12'd32) begin n_err++; $display("[TB] FAIL stop_pre32: got %0d expected 32", frequency); end
        stop = 1'b1; start = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd4) begin n_err++; $display("[TB] FAIL stop_state: got %0d expected 4", state); end
        wait_freq(12'd16, 8, ok, cyc);
        n_cmp++; if (!ok || state !== 3'd4) begin n_err++; $display("[TB] FAIL stop_16: got %0d/%0d expected 16/4", frequency, state); end
        wait_freq(12'd0, 8, ok, cyc);
        n_cmp++; if (!ok || cyc != 4) begin n_err++; $display("[TB] FAIL stop_0: got %0d after %0d expected 0 after 4", frequency, cyc); end
        tick();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL stop_idle: got %0d expected 0", state); end
        n_cmp++; if (pwm_en !== 1'b0 || u_str !== 12'd0) begin n_err++; $display("[TB] FAIL stop_outputs: got pwm=%0b u=%0d expected 0/0", pwm_en, u_str); end
        tick();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL stop_blocks_start: got %0d expected 0", state); end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_fault();
        bit ok;
        pulse_reset();
        target_freq = 12'd64; start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(3'd2, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL fault_reach_run: got %0d expected 2", state); end
        fault = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd5) begin n_err++; $display("[TB] FAIL fault_state: got %0d expected 5", state); end
        n_cmp++; if (frequency !== 12'd0 || pwm_en !== 1'b0 || u_str !== 12'd0) begin n_err++; $display("[TB] FAIL fault_outputs: got f=%0d pwm=%0b u=%0d expected 0/0/0", frequency, pwm_en, u_str); end
        fault_clr = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd5) begin n_err++; $display("[TB] FAIL fault_clr_ignored: got %0d expected 5", state); end
        fault = 1'b0;
        tick();
        fault_clr = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL fault_to_idle: got %0d expected 0", state); end
        n_cmp++; if (pwm_en !== 1'b0) begin n_err++; $display("[TB] FAIL fault_idle_pwm: got %0b expected 0", pwm_en); end
    endtask

    task automatic test_saturation();
        logic [11:0] prev;
        logic [12:0] exp13;
        bit wrapped;
        bit saw_4080;
        int cycles;
        pulse_reset();
        target_freq = 12'd4095; start = 1'b1;
        tick();
        start = 1'b0;
        prev = frequency;
        wrapped = 1'b0;
        saw_4080 = 1'b0;
        cycles = 0;
        while (state !== 3'd2 && cycles < 1200) begin
            tick();
            cycles++;
            exp13 = 13'(prev) + 13'd256;
            if (exp13 > 13'd4095) exp13 = 13'd4095;
            n_cmp++; if (u_str !== exp13[11:0]) begin n_err++; $display("[TB] FAIL sat_ustr: got %0d expected %0d", u_str, exp13); end
            if (frequency < prev) wrapped = 1'b1;
            if (frequency === 12'd4080) saw_4080 = 1'b1;
            prev = frequency;
        end
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL sat_run: got %0d expected 2", state); end
        n_cmp++; if (wrapped) begin n_err++; $display("[TB] FAIL sat_nowrap: got wrap expected monotonic"); end
        n_cmp++; if (!saw_4080) begin n_err++; $display("[TB] FAIL sat_4080: got missing expected step through 4080"); end
        n_cmp++; if (frequency !== 12'd4095) begin n_err++; $display("[TB] FAIL sat_freq: got %0d expected 4095", frequency); end
        n_cmp++; if (u_str !== 12'd4095) begin n_err++; $display("[TB] FAIL sat_ustr_final: got %0d expected 4095", u_str); end
        n_cmp++; if (at_speed !== 1'b1) begin n_err++; $display("[TB] FAIL sat_atspeed: got %0b expected 1", at_speed); end
    endtask

    task automatic test_reset_mid_accel();
        pulse_reset();
        target_freq = 12'd64; start = 1'b1;
        tick();
        repeat (6) tick();
        n_cmp++; if (frequency !== 12'd16) begin n_err++; $display("[TB] FAIL mid_pre: got %0d expected 16", frequency); end
        rst = 1'b1; fault = 1'b1;
        tick();
        rst = 1'b0; fault = 1'b0;
        n_cmp++; if (state !== 3'd0 || frequency !== 12'd0) begin n_err++; $display("[TB] FAIL mid_reset: got s=%0d f=%0d expected 0/0", state, frequency); end
        n_cmp++; if (u_str !== 12'd0 || pwm_en !== 1'b0 || at_speed !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_out: got u=%0d pwm=%0b as=%0b expected 0/0/0", u_str, pwm_en, at_speed); end
        tick();
        start = 1'b0;
        n_cmp++; if (state !== 3'd1 || frequency !== 12'd0) begin n_err++; $display("[TB] FAIL mid_restart: got s=%0d f=%0d expected 1/0", state, frequency); end
        repeat (3) tick();
        n_cmp++; if (frequency !== 12'd0) begin n_err++; $display("[TB] FAIL mid_presc: got %0d expected 0", frequency); end
        tick();
        n_cmp++; if (frequency !== 12'd16) begin n_err++; $display("[TB] FAIL mid_first_step: got %0d expected 16", frequency); end
    endtask

    initial begin
        test_reset();
        test_accel();
        test_decel();
        test_target_zero();
        test_stop();
        test_fault();
        test_saturation();
        test_reset_mid_accel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
